// File: rtl/operand_accumulator_60_13.sv
// Iterative accumulator: adds a stream of zero-extended IN_W-bit terms onto a
// seeded ACC_W-bit register and hands the total plus a sticky carry downstream.
module operand_accumulator_60_13 #(
  parameter int ACC_W    = 60,
  parameter int IN_W     = 13,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] init_value,
  input  logic [CNT_W-1:0] term_count,
  input  logic             b_valid,
  input  logic [IN_W-1:0]  b_data,
  output logic             b_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  output logic             res_carry,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // Wrap or clamp the carry-extended sum back to ACC_W bits.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
    if (SATURATE && s[ACC_W]) return '1;
    else                      return s[ACC_W-1:0];
  endfunction

  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, b_data};

  // State and datapath register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init_value;
          rem_d   = term_count;
          ovf_d   = 1'b0;
          state_d = (term_count != '0) ? S_ACC : S_OUT;
        end
      end
      S_ACC: begin
        if (b_valid) begin
          acc_d = sat_acc(sum);
          ovf_d = ovf_q | sum[ACC_W];
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced to zero outside OUT so nothing stale leaks downstream.
  always_comb begin
    b_ready   = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_carry = 1'b0;
    case (state_q)
      S_ACC: begin
        b_ready = 1'b1;
        busy    = 1'b1;
      end
      S_OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = acc_q;
        res_carry = ovf_q;
      end
      default: ;
    endcase
  end

endmodule
